// File: rtl/conv_pe_ctrl_gen.sv
// Sequencing controller for the CNN PE: walks element/window/filter/row loops
// with run-time bounds, MAC pipeline drain, output back-pressure and abort.
module conv_pe_ctrl_gen #(
  parameter int EW      = 4,
  parameter int WW      = 6,
  parameter int FW      = 3,
  parameter int RW      = 6,
  parameter int MAC_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  input  logic [EW-1:0] cfg_filt_len,
  input  logic [WW-1:0] cfg_num_win,
  input  logic [FW-1:0] cfg_num_filt,
  input  logic [RW-1:0] cfg_num_rows,
  input  logic          out_ready,
  output logic          busy,
  output logic          mac_en,
  output logic          acc_clr,
  output logic [EW-1:0] elem_idx,
  output logic [WW-1:0] win_idx,
  output logic [FW-1:0] filt_idx,
  output logic [RW-1:0] row_idx,
  output logic          out_we,
  output logic          win_done,
  output logic          filt_done,
  output logic          row_done,
  output logic          all_done,
  output logic          cfg_err
);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, WRITE, FIN} state_t;

  // Drain counter runs 0..MAC_LAT-1; kept at least one bit wide for MAC_LAT<=1.
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t        state_reg;
  logic [EW-1:0] len_reg;
  logic [WW-1:0] nwin_reg;
  logic [FW-1:0] nfilt_reg;
  logic [RW-1:0] nrows_reg;
  logic [EW-1:0] elem_reg;
  logic [WW-1:0] win_reg;
  logic [FW-1:0] filt_reg;
  logic [RW-1:0] row_reg;
  logic [DW-1:0] drain_reg;

  logic cfg_ok;
  logic last_elem;
  logic win_wrap;
  logic filt_wrap;
  logic row_wrap;
  logic last_job;
  logic accept;

  assign cfg_ok    = (|cfg_filt_len) && (|cfg_num_win) && (|cfg_num_filt) && (|cfg_num_rows);
  assign last_elem = (elem_reg == len_reg - EW'(1));
  assign win_wrap  = (win_reg == nwin_reg - WW'(1));
  assign filt_wrap = (filt_reg == nfilt_reg - FW'(1));
  assign row_wrap  = (row_reg == nrows_reg - RW'(1));
  assign last_job  = win_wrap && filt_wrap && row_wrap;
  assign accept    = (state_reg == WRITE) && out_ready && !abort;

  // Abort suppresses every datapath strobe in the cycle it is seen.
  assign busy      = (state_reg != IDLE);
  assign mac_en    = (state_reg == MAC) && !stall && !abort;
  assign acc_clr   = ((state_reg == LOAD) && !abort) || (accept && !last_job);
  assign out_we    = (state_reg == WRITE) && !abort;
  assign win_done  = accept;
  assign filt_done = accept && win_wrap;
  assign row_done  = accept && win_wrap && filt_wrap;
  assign all_done  = (state_reg == FIN) && !abort;
  assign cfg_err   = (state_reg == IDLE) && start && !cfg_ok;

  assign elem_idx  = elem_reg;
  assign win_idx   = win_reg;
  assign filt_idx  = filt_reg;
  assign row_idx   = row_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      nwin_reg  <= '0;
      nfilt_reg <= '0;
      nrows_reg <= '0;
      elem_reg  <= '0;
      win_reg   <= '0;
      filt_reg  <= '0;
      row_reg   <= '0;
      drain_reg <= '0;
    end else if (state_reg != IDLE && abort) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && cfg_ok) begin
            len_reg   <= cfg_filt_len;
            nwin_reg  <= cfg_num_win;
            nfilt_reg <= cfg_num_filt;
            nrows_reg <= cfg_num_rows;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          elem_reg  <= '0;
          win_reg   <= '0;
          filt_reg  <= '0;
          row_reg   <= '0;
          drain_reg <= '0;
          state_reg <= MAC;
        end
        MAC: begin
          if (!stall) begin
            if (last_elem) begin
              drain_reg <= '0;
              state_reg <= (MAC_LAT == 0) ? WRITE : DRAIN;
            end else begin
              elem_reg <= elem_reg + EW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_reg == DW'(MAC_LAT - 1)) begin
            state_reg <= WRITE;
          end else begin
            drain_reg <= drain_reg + DW'(1);
          end
        end
        WRITE: begin
          if (out_ready) begin
            elem_reg <= '0;
            if (win_wrap) begin
              win_reg <= '0;
              if (filt_wrap) begin
                filt_reg <= '0;
                row_reg  <= row_wrap ? '0 : row_reg + RW'(1);
              end else begin
                filt_reg <= filt_reg + FW'(1);
              end
            end else begin
              win_reg <= win_reg + WW'(1);
            end
            state_reg <= last_job ? FIN : MAC;
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pe_ctrl_gen.sv
// Directed bench for conv_pe_ctrl_gen: one MAC_LAT=2 instance and one MAC_LAT=0
// instance, cycle-exact expectations written out by hand.
module tb_conv_pe_ctrl_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start0 = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;
  logic out_ready = 1'b1;
  logic [3:0] cfg_filt_len = '0;
  logic [5:0] cfg_num_win = '0;
  logic [2:0] cfg_num_filt = '0;
  logic [5:0] cfg_num_rows = '0;

  logic busy, mac_en, acc_clr, out_we, win_done, filt_done, row_done, all_done, cfg_err;
  logic [3:0] elem_idx;
  logic [5:0] win_idx;
  logic [2:0] filt_idx;
  logic [5:0] row_idx;

  logic busy0, mac_en0, acc_clr0, out_we0, win_done0, filt_done0, row_done0, all_done0, cfg_err0;
  logic [3:0] elem_idx0;
  logic [5:0] win_idx0;
  logic [2:0] filt_idx0;
  logic [5:0] row_idx0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_pe_ctrl_gen #(.EW(4), .WW(6), .FW(3), .RW(6), .MAC_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .cfg_filt_len(cfg_filt_len), .cfg_num_win(cfg_num_win),
    .cfg_num_filt(cfg_num_filt), .cfg_num_rows(cfg_num_rows),
    .out_ready(out_ready), .busy(busy), .mac_en(mac_en), .acc_clr(acc_clr),
    .elem_idx(elem_idx), .win_idx(win_idx), .filt_idx(filt_idx), .row_idx(row_idx),
    .out_we(out_we), .win_done(win_done), .filt_done(filt_done), .row_done(row_done),
    .all_done(all_done), .cfg_err(cfg_err)
  );

  conv_pe_ctrl_gen #(.EW(4), .WW(6), .FW(3), .RW(6), .MAC_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .stall(stall),
    .cfg_filt_len(cfg_filt_len), .cfg_num_win(cfg_num_win),
    .cfg_num_filt(cfg_num_filt), .cfg_num_rows(cfg_num_rows),
    .out_ready(out_ready), .busy(busy0), .mac_en(mac_en0), .acc_clr(acc_clr0),
    .elem_idx(elem_idx0), .win_idx(win_idx0), .filt_idx(filt_idx0), .row_idx(row_idx0),
    .out_we(out_we0), .win_done(win_done0), .filt_done(filt_done0), .row_done(row_done0),
    .all_done(all_done0), .cfg_err(cfg_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] em, ew, ec, ed, eb, ef;
    int nm, nw, wn;
    logic seen;

    // Reset state
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mac_en, acc_clr, out_we, win_done, filt_done, row_done, all_done, cfg_err}, 0);
    chk("rst_idx", {elem_idx, win_idx, filt_idx, row_idx}, 0);

    // Test 1: len=3 win=2 filt=1 rows=1, start in cycle 0
    cfg_filt_len = 4'd3; cfg_num_win = 6'd2; cfg_num_filt = 3'd1; cfg_num_rows = 6'd1;
    cyc(); start = 1'b1; #1;
    chk("t1_c0_cfg_err", cfg_err, 0);
    chk("t1_c0_busy", busy, 0);
    em = 16'h071C; ew = 16'h2080; ec = 16'h0082; ed = 16'h4000; eb = 16'h7FFE; ef = 16'h2000;
    nm = 0; nw = 0;
    for (int c = 1; c <= 15; c++) begin
      cyc(); start = 1'b0; #1;
      chk($sformatf("t1_mac_c%0d", c), mac_en, em[c]);
      chk($sformatf("t1_we_c%0d", c), out_we, ew[c]);
      chk($sformatf("t1_clr_c%0d", c), acc_clr, ec[c]);
      chk($sformatf("t1_done_c%0d", c), all_done, ed[c]);
      chk($sformatf("t1_busy_c%0d", c), busy, eb[c]);
      chk($sformatf("t1_windone_c%0d", c), win_done, ew[c]);
      chk($sformatf("t1_filtrow_c%0d", c), {filt_done, row_done}, {ef[c], ef[c]});
      if (c == 3) chk("t1_elem_c3", elem_idx, 1);
      if (c == 7) chk("t1_elem_c7", elem_idx, 2);
      if (mac_en) nm++;
      if (out_we) nw++;
    end
    chk("t1_mac_total", nm, 6);
    chk("t1_we_total", nw, 2);

    // Test 2: stall in cycles 3-4; start together with abort in IDLE
    cyc(); start = 1'b1; abort = 1'b1; #1;
    chk("t2_c0_cfg_err", cfg_err, 0);
    em = 16'h0064;
    for (int c = 1; c <= 9; c++) begin
      cyc(); start = 1'b0; abort = 1'b0; stall = (c == 3 || c == 4); #1;
      chk($sformatf("t2_mac_c%0d", c), mac_en, em[c]);
      chk($sformatf("t2_we_c%0d", c), out_we, (c == 9));
      if (c == 1) chk("t2_busy_c1", busy, 1);
      if (c == 3 || c == 4) chk($sformatf("t2_elem_c%0d", c), elem_idx, 1);
    end
    stall = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(); #1;
      if (all_done) seen = 1'b1;
    end
    chk("t2_all_done_seen", seen, 1);
    cyc(); #1;
    chk("t2_idle_after", busy, 0);

    // Test 3: MAC_LAT=0 instance, len=2 win=2 filt=2 rows=2
    cfg_filt_len = 4'd2; cfg_num_win = 6'd2; cfg_num_filt = 3'd2; cfg_num_rows = 6'd2;
    cyc(); start0 = 1'b1; #1;
    wn = 0; seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      cyc(); start0 = 1'b0; #1;
      if (out_we0) begin
        wn++;
        chk($sformatf("t3_windone_w%0d", wn), win_done0, 1);
        chk($sformatf("t3_filtdone_w%0d", wn), filt_done0, (wn % 2 == 0));
        chk($sformatf("t3_rowdone_w%0d", wn), row_done0, (wn % 4 == 0));
        if (wn == 8) chk("t3_idx_w8", {row_idx0, filt_idx0, win_idx0}, {6'd1, 3'd1, 6'd1});
      end
      if (all_done0) seen = 1'b1;
    end
    chk("t3_we_total", wn, 8);
    chk("t3_all_done_seen", seen, 1);
    chk("t3_other_idle", busy, 0);

    // Test 4: back-pressure at first WRITE, then abort mid-MAC
    cfg_filt_len = 4'd3; cfg_num_win = 6'd2; cfg_num_filt = 3'd1; cfg_num_rows = 6'd1;
    cyc(); start = 1'b1; #1;
    for (int c = 1; c <= 15; c++) begin
      cyc(); start = 1'b0; out_ready = !(c >= 7 && c <= 11); abort = (c == 14); #1;
      if (c >= 7 && c <= 12) begin
        chk($sformatf("t4_we_c%0d", c), out_we, 1);
        chk($sformatf("t4_windone_c%0d", c), win_done, (c == 12));
        chk($sformatf("t4_win_c%0d", c), win_idx, 0);
        chk($sformatf("t4_elem_c%0d", c), elem_idx, 2);
      end
      if (c == 13) begin
        chk("t4_we_c13", out_we, 0);
        chk("t4_mac_c13", mac_en, 1);
        chk("t4_win_c13", win_idx, 1);
        chk("t4_elem_c13", elem_idx, 0);
      end
      if (c == 14) chk("t4_abort_busy_c14", busy, 1);
      if (c == 15) begin
        chk("t4_abort_busy_c15", busy, 0);
        chk("t4_abort_we_c15", out_we, 0);
        chk("t4_abort_done_c15", {win_done, all_done}, 0);
      end
    end
    abort = 1'b0; out_ready = 1'b1;

    // Test 5: zero filter count rejected
    cfg_num_filt = 3'd0;
    cyc(); start = 1'b1; #1;
    chk("t5_cfg_err", cfg_err, 1);
    chk("t5_busy_c0", busy, 0);
    cyc(); start = 1'b0; #1;
    chk("t5_busy_c1", busy, 0);
    chk("t5_cfg_err_c1", cfg_err, 0);

    // Test 6: reset during DRAIN
    cfg_num_filt = 3'd1;
    cyc(); start = 1'b1; #1;
    for (int c = 1; c <= 5; c++) begin
      cyc(); start = 1'b0; #1;
    end
    chk("t6_drain_busy", busy, 1);
    chk("t6_drain_elem", elem_idx, 2);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_strobes", {mac_en, acc_clr, out_we, win_done, filt_done, row_done, all_done, cfg_err}, 0);
    chk("t6_rst_idx", {elem_idx, win_idx, filt_idx, row_idx}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
